sb_param_shadow: RTL and testbench
==================================

Name: sb_param_shadow

Overview:
- Parametrised successor to the fixed 2-input switch block at grid corner [0][0]: a top/right corner switch block with CHAN_WIDTH tracks per side and a 4-way selection per output track.
- Configuration is loaded serially on the ccff chain into a shadow register.
- A commit pulse copies the shadow to the active configuration atomically, so routing never sees partial bitstreams.
- A shift counter checks the bit count, and a bad commit is rejected with an error flag.
- Routing data path is combinational. Configuration path is sequential on prog_clk.

Parameters:
- CHAN_WIDTH, 9, tracks per channel side (>=2).
- NUM_PINS, 8, grid pins per side feeding the block (>=1).
- TOTAL_BITS, 4*CHAN_WIDTH (derived, localparam), config bits; 2 per output mux, 2*CHAN_WIDTH muxes.
- CNT_W, clog2(TOTAL_BITS+2) (derived, localparam), shift counter width.

Ports:
- prog_clk  in  1  configuration clock; only clock.
- prog_reset_n  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial config data in.
- cfg_shift_en  in  1  shift one bit per cycle while high.
- cfg_commit  in  1  single-cycle request to load shadow into active.
- ccff_tail  out  1  last shadow bit; chains to next block.
- cfg_ready  out  1  exactly TOTAL_BITS shifted since last commit/reset.
- cfg_valid  out  1  active config holds a committed bitstream.
- cfg_err  out  1  sticky: last commit rejected.
- chany_top_in  in  CHAN_WIDTH  top channel incoming tracks.
- chanx_right_in  in  CHAN_WIDTH  right channel incoming tracks.
- top_grid_pin  in  NUM_PINS  top-left grid output pins.
- right_grid_pin  in  NUM_PINS  right-bottom grid output pins.
- chany_top_out  out  CHAN_WIDTH  top channel driven tracks.
- chanx_right_out  out  CHAN_WIDTH  right channel driven tracks.

Behaviour:
- Reset, asynchronous on the prog_reset_n low level:
  - shadow S=0, active A=0, cnt=0.
  - cfg_valid=0, cfg_err=0, ccff_tail=0, cfg_ready=0.
  - All routing outputs are 0, because code 0 selects tie-0.
- Shift (cfg_shift_en=1, cfg_commit=0), per posedge:
  - S[0]<=ccff_head, S[i]<=S[i-1].
  - ccff_tail=S[TOTAL_BITS-1], registered.
  - cnt<=cnt+1, saturating at TOTAL_BITS+1 (overshift).
- Counter-derived states:
  - EMPTY: cnt=0.
  - LOADING: 0<cnt<TOTAL_BITS.
  - FULL: cnt=TOTAL_BITS; cfg_ready=1 only here.
  - OVER: cnt=TOTAL_BITS+1.
- Commit when FULL:
  - A<=S at that edge.
  - cnt<=0, cfg_valid<=1, cfg_err<=0.
  - New routing is visible combinationally after the edge.
- Commit when not FULL:
  - A unchanged, cnt<=0, cfg_err<=1, cfg_valid unchanged.
- Commit and shift in the same cycle:
  - Commit wins and the shift is dropped; S is unchanged.
  - The commit is judged on the pre-edge cnt.
- Commit is level-sampled. If held high for several cycles, each cycle is evaluated; the second cycle sees cnt=0 and sets cfg_err. Drivers pulse commit for one cycle.
- Config bit mapping:
  - Mux k uses sel_k={A[2k+1],A[2k]}.
  - k=0..CHAN_WIDTH-1 is top track t=k.
  - k=CHAN_WIDTH..2*CHAN_WIDTH-1 is right track t=k-CHAN_WIDTH.
  - The first bit shifted in ends at S[TOTAL_BITS-1].
- Top output t, by sel code:
  - 0: 0.
  - 1: top_grid_pin[t mod NUM_PINS].
  - 2: chanx_right_in[(t+1) mod CHAN_WIDTH].
  - 3: chanx_right_in[t].
- Right output t, by sel code:
  - 0: 0.
  - 1: right_grid_pin[t mod NUM_PINS].
  - 2: chany_top_in[(t+CHAN_WIDTH-1) mod CHAN_WIDTH].
  - 3: chany_top_in[t].
- Wrap-around: the cross-track index wraps modulo CHAN_WIDTH, so top t=8 uses right track 0 when CHAN_WIDTH=9.
- Reset mid-shift or mid-commit: everything returns to reset values; the partial bitstream is lost and A is cleared.

Test Plan:
- Reset, then drive all inputs high -> all outputs 0; cfg_valid=0, cfg_ready=0, cfg_err=0.
- CHAN_WIDTH=9: shift 36 bits with every sel=3, then pulse commit -> cfg_ready=1 before commit; after commit chany_top_out==chanx_right_in and chanx_right_out==chany_top_in, cfg_valid=1, cfg_ready=0.
- Shift 35 bits, then commit -> cfg_err=1, outputs keep the previous config. Then 36 good bits plus commit -> cfg_err=0.
- Shift 37 bits -> cfg_ready drops after bit 37; commit -> cfg_err=1. Check ccff_tail equals the bit shifted 36 cycles earlier.
- All sel=2 with chanx_right_in=9'b000000001 -> chany_top_out has only bit 8 high (wrap). Then shift and commit held in the same cycle -> S unchanged, commit judged on the old count.
- Assert prog_reset_n low asynchronously mid-shift (between edges) -> outputs 0 immediately, cnt=0, cfg_valid=0. Repeat with CHAN_WIDTH=4, NUM_PINS=2 and sel=1 -> top out t=3 follows top_grid_pin[1].

Source files
------------

// File: rtl/sb_param_shadow.sv
// Corner switch block (top/right) with CHAN_WIDTH tracks per side and a 4:1 selector per output track.
// Configuration shifts serially into a shadow register and is copied to the active set on a checked commit.
module sb_param_shadow #(
  parameter int CHAN_WIDTH = 9,
  parameter int NUM_PINS   = 8
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  ccff_head,
  input  logic                  cfg_shift_en,
  input  logic                  cfg_commit,
  output logic                  ccff_tail,
  output logic                  cfg_ready,
  output logic                  cfg_valid,
  output logic                  cfg_err,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [NUM_PINS-1:0]   top_grid_pin,
  input  logic [NUM_PINS-1:0]   right_grid_pin,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out
);

  localparam int TOTAL_BITS = 4 * CHAN_WIDTH;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL_BITS + 1);

  // Load state decoded from the shift counter; cfg_state is the probe point for checkers.
  typedef enum logic [1:0] {
    CFG_EMPTY   = 2'd0,
    CFG_LOADING = 2'd1,
    CFG_FULL    = 2'd2,
    CFG_OVER    = 2'd3
  } cfg_state_e;

  cfg_state_e                cfg_state;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;
  logic [TOTAL_BITS-1:0]     shadow_q;
  logic [TOTAL_BITS-1:0]     active_q;
  logic                      valid_q;
  logic                      err_q;
  logic                      do_shift;
  logic                      commit_ok;
  logic                      commit_bad;

  always_comb begin
    cfg_state = CFG_EMPTY;
    if (cnt_q == CNT_ZERO) begin
      cfg_state = CFG_EMPTY;
    end else if (cnt_q == CNT_FULL) begin
      cfg_state = CFG_FULL;
    end else if (cnt_q == CNT_OVER) begin
      cfg_state = CFG_OVER;
    end else begin
      cfg_state = CFG_LOADING;
    end
  end

  // Control protocol: cfg_shift_en is a level, one bit accepted per prog_clk edge while high;
  // cfg_commit is sampled every edge, takes priority over a shift in the same cycle (the shift is
  // dropped), is judged on the pre-edge count, and always returns the counter to EMPTY.
  always_comb begin
    cnt_d      = cnt_q;
    do_shift   = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    if (cfg_commit) begin
      cnt_d = CNT_ZERO;
      if (cfg_state == CFG_FULL) begin
        commit_ok = 1'b1;
      end else begin
        commit_bad = 1'b1;
      end
    end else if (cfg_shift_en) begin
      do_shift = 1'b1;
      if (cfg_state != CFG_OVER) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      cnt_q    <= CNT_ZERO;
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_shift) begin
        shadow_q <= {shadow_q[TOTAL_BITS-2:0], ccff_head};
      end
      if (commit_ok) begin
        active_q <= shadow_q;
        valid_q  <= 1'b1;
        err_q    <= 1'b0;
      end
      if (commit_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ccff_tail = shadow_q[TOTAL_BITS-1];
  assign cfg_ready = (cfg_state == CFG_FULL);
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  // Top track t: mux k=t; cross source is the right channel, shifted up by one with wrap.
  for (genvar t = 0; t < CHAN_WIDTH; t++) begin : g_top
    localparam int PIN = t % NUM_PINS;
    localparam int XT  = (t + 1) % CHAN_WIDTH;
    logic [1:0] sel;
    logic       o;

    assign sel = active_q[2*t +: 2];

    always_comb begin
      o = 1'b0;
      case (sel)
        2'd1:    o = top_grid_pin[PIN];
        2'd2:    o = chanx_right_in[XT];
        2'd3:    o = chanx_right_in[t];
        default: o = 1'b0;
      endcase
    end

    assign chany_top_out[t] = o;
  end

  // Right track t: mux k=CHAN_WIDTH+t; cross source is the top channel, shifted down by one with wrap.
  for (genvar t = 0; t < CHAN_WIDTH; t++) begin : g_right
    localparam int PIN = t % NUM_PINS;
    localparam int XT  = (t + CHAN_WIDTH - 1) % CHAN_WIDTH;
    logic [1:0] sel;
    logic       o;

    assign sel = active_q[2*(CHAN_WIDTH+t) +: 2];

    always_comb begin
      o = 1'b0;
      case (sel)
        2'd1:    o = right_grid_pin[PIN];
        2'd2:    o = chany_top_in[XT];
        2'd3:    o = chany_top_in[t];
        default: o = 1'b0;
      endcase
    end

    assign chanx_right_out[t] = o;
  end

endmodule

// File: tb/tb_sb_param_shadow.sv
// Directed bench for sb_param_shadow: default 9-track instance plus a 4-track/2-pin instance
// for the grid-pin modulo mapping and asynchronous reset.
module tb_sb_param_shadow;

  localparam int CW  = 9;
  localparam int NP  = 8;
  localparam int TB  = 4 * CW;
  localparam int CW4 = 4;
  localparam int NP4 = 2;
  localparam int TB4 = 4 * CW4;
  localparam int NV  = 7;

  // ---------------- clock / reset ----------------
  logic prog_clk;
  logic prog_reset_n;

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 9-track ----------------
  logic          ccff_head, cfg_shift_en, cfg_commit;
  logic          ccff_tail, cfg_ready, cfg_valid, cfg_err;
  logic [CW-1:0] chany_top_in, chanx_right_in, chany_top_out, chanx_right_out;
  logic [NP-1:0] top_grid_pin, right_grid_pin;

  sb_param_shadow #(.CHAN_WIDTH(CW), .NUM_PINS(NP)) dut (
    .prog_clk        (prog_clk),
    .prog_reset_n    (prog_reset_n),
    .ccff_head       (ccff_head),
    .cfg_shift_en    (cfg_shift_en),
    .cfg_commit      (cfg_commit),
    .ccff_tail       (ccff_tail),
    .cfg_ready       (cfg_ready),
    .cfg_valid       (cfg_valid),
    .cfg_err         (cfg_err),
    .chany_top_in    (chany_top_in),
    .chanx_right_in  (chanx_right_in),
    .top_grid_pin    (top_grid_pin),
    .right_grid_pin  (right_grid_pin),
    .chany_top_out   (chany_top_out),
    .chanx_right_out (chanx_right_out)
  );

  // ---------------- DUT 4-track ----------------
  logic           h4, en4, cm4, tail4, ready4, valid4, err4;
  logic [CW4-1:0] chy4, chx4, top4, right4;
  logic [NP4-1:0] tp4, rp4;

  sb_param_shadow #(.CHAN_WIDTH(CW4), .NUM_PINS(NP4)) dut4 (
    .prog_clk        (prog_clk),
    .prog_reset_n    (prog_reset_n),
    .ccff_head       (h4),
    .cfg_shift_en    (en4),
    .cfg_commit      (cm4),
    .ccff_tail       (tail4),
    .cfg_ready       (ready4),
    .cfg_valid       (valid4),
    .cfg_err         (err4),
    .chany_top_in    (chy4),
    .chanx_right_in  (chx4),
    .top_grid_pin    (tp4),
    .right_grid_pin  (rp4),
    .chany_top_out   (top4),
    .chanx_right_out (right4)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         sh_cnt;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [1:0]    cfg;
    logic [CW-1:0] chy;
    logic [CW-1:0] chx;
    logic [NP-1:0] tp;
    logic [NP-1:0] rp;
    logic [CW-1:0] exp_top;
    logic [CW-1:0] exp_right;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic v, input logic r, input logic e);
    check({tag, "_valid"}, 32'(cfg_valid), 32'(v));
    check({tag, "_ready"}, 32'(cfg_ready), 32'(r));
    check({tag, "_err"},   32'(cfg_err),   32'(e));
  endtask

  // Shadow model: front is S[0]; the tail is element TB-1.
  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < TB; i++) exp_q.push_back(1'b0);
    sh_cnt = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic shift9(input logic b);
    ccff_head    = b;
    cfg_shift_en = 1'b1;
    @(posedge prog_clk);
    exp_q.push_front(b);
    void'(exp_q.pop_back());
    if (sh_cnt < TB + 1) sh_cnt++;
    #1;
    cfg_shift_en = 1'b0;
    check($sformatf("ccff_tail@%0d", sh_cnt), 32'(ccff_tail), 32'(exp_q[TB-1]));
    check($sformatf("cfg_ready@%0d", sh_cnt), 32'(cfg_ready), 32'(sh_cnt == TB));
  endtask

  // Shifts the first n bits of a, MSB first, so a full load leaves A == a.
  task automatic load9(input logic [TB-1:0] a, input int n);
    for (int j = 0; j < n; j++) shift9(a[TB-1-j]);
  endtask

  task automatic commit9();
    cfg_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_commit = 1'b0;
    sh_cnt     = 0;
  endtask

  task automatic run_vecs(input logic [1:0] cfg);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].cfg == cfg) begin
        chany_top_in   = vecs[i].chy;
        chanx_right_in = vecs[i].chx;
        top_grid_pin   = vecs[i].tp;
        right_grid_pin = vecs[i].rp;
        #1;
        check($sformatf("top_out[v%0d]", i),   32'(chany_top_out),   32'(vecs[i].exp_top));
        check($sformatf("right_out[v%0d]", i), 32'(chanx_right_out), 32'(vecs[i].exp_right));
      end
    end
  endtask

  task automatic shift4(input logic b);
    h4  = b;
    en4 = 1'b1;
    @(posedge prog_clk);
    #1;
    en4 = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    // sel=3: straight through; sel=2: top rotates down by one, right rotates up by one; sel=0: tie-0
    vecs[0] = '{2'd3, 9'h1A5, 9'h0F3, 8'hFF, 8'hFF, 9'h0F3, 9'h1A5};
    vecs[1] = '{2'd3, 9'h000, 9'h1FF, 8'hFF, 8'h00, 9'h1FF, 9'h000};
    vecs[2] = '{2'd3, 9'h155, 9'h0AA, 8'h00, 8'hFF, 9'h0AA, 9'h155};
    vecs[3] = '{2'd2, 9'b000000001, 9'b000000001, 8'hFF, 8'hFF, 9'b100000000, 9'b000000010};
    vecs[4] = '{2'd2, 9'b100000000, 9'b100000000, 8'h00, 8'h00, 9'b010000000, 9'b000000001};
    vecs[5] = '{2'd2, 9'b110000011, 9'b110000011, 8'hA5, 8'h5A, 9'b111000001, 9'b100000111};
    vecs[6] = '{2'd0, 9'h1FF, 9'h1FF, 8'hFF, 8'hFF, 9'h000, 9'h000};

    prog_reset_n = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    en4 = 1'b0; cm4 = 1'b0; h4 = 1'b0;
    chy4 = '0; chx4 = '0; tp4 = '0; rp4 = '0;
    model_clear();

    // Reset with every input high: nothing routes, nothing flagged.
    ccff_head      = 1'b1;
    chany_top_in   = '1;
    chanx_right_in = '1;
    top_grid_pin   = '1;
    right_grid_pin = '1;
    repeat (2) @(posedge prog_clk);
    #1;
    check("rst_top_out", 32'(chany_top_out), 32'h0);
    check("rst_right_out", 32'(chanx_right_out), 32'h0);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    @(posedge prog_clk);
    #1;
    check("post_rst_top_out", 32'(chany_top_out), 32'h0);
    check_status("post_rst", 1'b0, 1'b0, 1'b0);

    // Every sel=3, good commit.
    load9({18{2'b11}}, TB);
    commit9();
    check_status("commit_sel3", 1'b1, 1'b0, 1'b0);
    run_vecs(2'd3);

    // Short load (35 bits) is rejected; sel=3 routing stays.
    load9('0, TB - 1);
    commit9();
    check_status("short_commit", 1'b1, 1'b0, 1'b1);
    run_vecs(2'd3);

    // Good sel=2 load clears the error; exercises the wrap-around.
    load9({18{2'b10}}, TB);
    commit9();
    check_status("commit_sel2", 1'b1, 1'b0, 1'b0);
    run_vecs(2'd2);

    // Overshift by one: ready drops on bit 37, commit rejected.
    for (int j = 0; j < TB + 1; j++) shift9(1'($urandom_range(0, 1)));
    commit9();
    check_status("over_commit", 1'b1, 1'b0, 1'b1);
    run_vecs(2'd2);

    // Shift+commit in one cycle: commit wins on the pre-edge count, shift dropped.
    load9({18{2'b11}}, TB);
    ccff_head    = 1'b0;
    cfg_shift_en = 1'b1;
    cfg_commit   = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    sh_cnt       = 0;
    check_status("shift_commit", 1'b1, 1'b0, 1'b0);
    check("shift_commit_tail", 32'(ccff_tail), 32'(exp_q[TB-1]));
    run_vecs(2'd3);
    // The dropped 0 would surface at the tail on the 35th shift below.
    load9('0, TB);

    // Commit held two cycles: first loads sel=0, second sees an empty count.
    cfg_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    check_status("hold_c1", 1'b1, 1'b0, 1'b0);
    @(posedge prog_clk);
    #1;
    cfg_commit = 1'b0;
    sh_cnt     = 0;
    check_status("hold_c2", 1'b1, 1'b0, 1'b1);
    run_vecs(2'd0);

    // Asynchronous reset between edges, mid-shift.
    load9({18{2'b11}}, TB);
    commit9();
    commit9();
    check_status("pre_async", 1'b1, 1'b0, 1'b1);
    chany_top_in   = '1;
    chanx_right_in = '1;
    ccff_head      = 1'b1;
    cfg_shift_en   = 1'b1;
    @(posedge prog_clk);
    #1;
    check("pre_async_top_out", 32'(chany_top_out), 32'h1FF);
    #2;
    prog_reset_n = 1'b0;
    #1;
    check("async_top_out", 32'(chany_top_out), 32'h0);
    check("async_right_out", 32'(chanx_right_out), 32'h0);
    check("async_tail", 32'(ccff_tail), 32'h0);
    check_status("async", 1'b0, 1'b0, 1'b0);
    cfg_shift_en = 1'b0;
    model_clear();
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    // Ready must appear exactly on bit 36 again, proving the count restarted at 0.
    load9('0, TB);

    // 4-track / 2-pin instance, every sel=1: top[t] = top_grid_pin[t mod 2].
    for (int j = 0; j < TB4; j++) begin
      logic [TB4-1:0] pat;
      pat = {8{2'b01}};
      shift4(pat[TB4-1-j]);
      if (j == TB4 - 2) check("w4_ready_15", 32'(ready4), 32'h0);
    end
    check("w4_ready_16", 32'(ready4), 32'h1);
    cm4 = 1'b1;
    @(posedge prog_clk);
    #1;
    cm4 = 1'b0;
    check("w4_valid", 32'(valid4), 32'h1);
    check("w4_err", 32'(err4), 32'h0);
    chy4 = '1;
    chx4 = '1;
    tp4  = 2'b10;
    rp4  = 2'b01;
    #1;
    check("w4_top_a", 32'(top4), 32'b1010);
    check("w4_right_a", 32'(right4), 32'b0101);
    check("w4_top3_pin1", 32'(top4[3]), 32'(tp4[1]));
    tp4 = 2'b01;
    rp4 = 2'b10;
    #1;
    check("w4_top_b", 32'(top4), 32'b0101);
    check("w4_right_b", 32'(right4), 32'b1010);
    check("w4_top3_pin1_b", 32'(top4[3]), 32'(tp4[1]));

    tp4 = 2'b11;
    rp4 = 2'b11;
    h4  = 1'b1;
    en4 = 1'b1;
    @(posedge prog_clk);
    #3;
    check("w4_pre_async_top", 32'(top4), 32'hF);
    prog_reset_n = 1'b0;
    #1;
    check("w4_async_top", 32'(top4), 32'h0);
    check("w4_async_right", 32'(right4), 32'h0);
    check("w4_async_valid", 32'(valid4), 32'h0);
    check("w4_async_ready", 32'(ready4), 32'h0);
    en4 = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    repeat (2) @(posedge prog_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
